cvt_w_s: RTL and testbench
==========================

# cvt_w_s

Pipelined binary32-to-signed-32-bit-integer converter with IEEE 754 rounding. It implements the MIPS cvt.w.s datapath and is the inverse of the cvt.s.w integer-to-float path. It accepts one float per cycle over a valid/ready handshake and produces the rounded integer three cycles later. It also reports invalid and inexact flags using the same one-hot rounding-attribute encoding as the rest of the FPU.

## Interface
- INTn, 32, integer result width
- NEXP, 8, exponent field width
- NSIG, 23, stored significand width (hidden bit excluded)
- BIAS, 127, exponent bias
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block accepts an operand this cycle
- in_float  in  NEXP+NSIG+1  binary32 operand {sign, exp, frac}
- ra  in  LAST_RA+1  one-hot rounding attribute, sampled with in_float
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_int  out  INTn  two's-complement result
- out_invalid  out  1  NaN, infinity, or out of range
- out_inexact  out  1  result differs from operand, valid only when out_invalid=0

## Operation
- **Transfer rules.**
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- **S1 unpack.** Register the following:
  - sign
  - unbiased E = exp − BIAS, signed NEXP+1 bits
  - sig24 = {exp≠0, frac}
  - class: zero, denormal, normal, inf, NaN
  - ra
- **S2 align.**
  - 0 ≤ E ≤ 23: mag = sig24 >> (23−E). guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - 24 ≤ E ≤ 30: mag = sig24 << (E−23); guard = sticky = 0.
  - E = −1: mag = 0, guard = 1, sticky = |frac.
  - E ≤ −2 or denormal: mag = 0, guard = 0, sticky = 1.
  - Zero: mag = 0, guard = sticky = 0.
  - E ≥ 31, inf, or NaN: set the ovf flag. The one exception is sign=1, E=31, frac=0, which gives mag = 2^31 exactly.
  - mag is INTn bits unsigned.
- **S3 round / negate / saturate.**
  - roundBit is set by:
    - roundTiesToEven & guard & (mag[0] | sticky)
    - roundTowardPositive & ~sign & (guard | sticky)
    - roundTowardNegative & sign & (guard | sticky)
  - roundTowardZero always truncates.
  - rmag = mag + roundBit, INTn+1 bits.
  - Overflow cases:
    - rmag > 2^31−1 with sign=0, or rmag > 2^31 with sign=1: treated as ovf.
    - ovf or NaN: out_int = 0x7FFFFFFF, out_invalid = 1, out_inexact = 0. This applies to both signs (MIPS default result).
  - Otherwise:
    - out_int = sign ? −rmag : rmag.
    - out_inexact = guard | sticky.
  - −0.0 yields 0x00000000 with no flags.
- **Stall.** en = ~out_valid | out_ready. All stage registers, valids included, load only when en. in_ready = en. A stall holds every stage, so bubbles are not squeezed out.

## Timing
- Latency: 3 cycles from input transfer to out_valid, when there is no stall.
- Throughput: 1 result per cycle.
- Reset values (asynchronous, immediate): all stage valids 0, out_valid 0, out_int 0, out_invalid 0, out_inexact 0.
  - in_ready = 1 in the first cycle after reset deassertion.
- Output stability: while out_valid & ~out_ready, out_int and the flags hold stable and in_ready = 0.
- Simultaneous out_ready and in_valid in the same cycle: the pipeline advances, and the new operand enters S1 that edge.
- Reset mid-operation: all in-flight operands are discarded. No result is emitted for them after reset releases.
- ra changes mid-flight: no effect on operands already accepted, because each operand carries its own ra.

## Structure
- Rounding-attribute names and LAST_RA come from the shared ieee-754-flags include; no local redefinition.
- Class encodings (zero, denormal, normal, inf, NaN) and the saturation constants 0x7FFFFFFF and 0x80000000 go in the same shared package.
- One sub-module, rshift_sticky: a combinational right-shift barrel shifter returning {mag, guard, sticky}. It is instantiated in S2.

## Test plan
- RNE rounding: 0x3FC00000 (1.5) → 2, inexact=1. 0x40200000 (2.5) → 2, inexact=1. 0xC0200000 (−2.5) with roundTowardNegative → 0xFFFFFFFD (−3).
- Directed rounding of tiny values: 0x00000001 (denormal) with roundTowardPositive → 1, inexact=1. The same operand with roundTowardZero → 0, inexact=1. 0x80000000 → 0, no flags.
- Range edge: 0xCF000000 (−2^31) → 0x80000000, no flags. 0x4F000000 (2^31) → 0x7FFFFFFF, invalid=1. 0x4EFFFFFF → 0x7FFFFF80, no flags.
- Specials: 0x7FC00000 (NaN), 0x7F800000 (+inf), and 0xFF800000 (−inf) → 0x7FFFFFFF, invalid=1, inexact=0.
- Backpressure: stream 8 operands back-to-back while holding out_ready=0 for cycles 4–9. Required response:
  - in_ready drops once a result is held.
  - No result is lost or duplicated, and order is preserved.
  - out_int stays stable while stalled.
  - After release, results come out one per cycle.
- Reset: assert rst with 3 operands in flight. Required response:
  - out_valid drops immediately.
  - No stale result appears after release.
  - The next operand's result appears exactly 3 cycles after its transfer.

Source files
------------

// File: rtl/cvt_w_s_pkg.sv
// Shared FPU definitions: one-hot rounding attributes, operand classes and
// integer saturation constants used by the float-to-integer converter.
package cvt_w_s_pkg;

   // Bit positions inside the one-hot rounding-attribute vector.
   localparam int LAST_RA             = 3;
   localparam int roundTiesToEven     = 0;
   localparam int roundTowardZero     = 1;
   localparam int roundTowardPositive = 2;
   localparam int roundTowardNegative = 3;

   localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_NEG = 32'h8000_0000;

   typedef enum logic [2:0] {
      clsZero,
      clsDenorm,
      clsNormal,
      clsInf,
      clsNan
   } fpClass_t;

endpackage

// File: rtl/cvt_w_s_rshift_sticky.sv
// Right-shift barrel shifter that keeps the first dropped bit as guard and
// ORs every other dropped bit into sticky.
module rshift_sticky
   import cvt_w_s_pkg::*;
#(
   parameter int SIGW = 24,
   parameter int OUTW = 32,
   parameter int SHW  = 5
) (
   input  logic [SIGW-1:0] sig,
   input  logic [SHW-1:0]  shAmt,
   output logic [OUTW-1:0] mag,
   output logic            guard,
   output logic            sticky
);

   localparam int W = OUTW + SIGW;

   logic [W-1:0] wide;

   // The low SIGW bits catch everything shifted out of the integer part.
   assign wide   = {{(OUTW - SIGW){1'b0}}, sig, {SIGW{1'b0}}} >> shAmt;
   assign mag    = wide[W-1:SIGW];
   assign guard  = wide[SIGW-1];
   assign sticky = |wide[SIGW-2:0];

endmodule

// File: rtl/cvt_w_s.sv
// Three-stage binary32 to signed 32-bit integer converter (cvt.w.s) with
// one-hot rounding attribute, invalid/inexact flags and whole-pipe stall.
module cvt_w_s
   import cvt_w_s_pkg::*;
#(
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 23,
   parameter int BIAS = 127
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NEXP+NSIG:0]   in_float,
   input  logic [LAST_RA:0]     ra,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INTn-1:0]      out_int,
   output logic                 out_invalid,
   output logic                 out_inexact
);

   localparam int SHW = $clog2(NSIG + 2);
   localparam logic signed [NEXP:0] E_SIG  = (NEXP+1)'(NSIG);
   localparam logic signed [NEXP:0] E_SAT  = (NEXP+1)'(INTn - 1);
   localparam logic signed [NEXP:0] E_ZERO = '0;
   localparam logic signed [NEXP:0] E_NEG1 = '1;

   function automatic logic roundUp(input logic [LAST_RA:0] mode, input logic sgn,
                                    input logic lsb, input logic grd, input logic stk);
      logic up;
      up = (mode[roundTiesToEven] & grd & (lsb | stk))
         | (mode[roundTowardPositive] & ~sgn & (grd | stk))
         | (mode[roundTowardNegative] & sgn & (grd | stk));
      if (mode[roundTowardZero]) up = 1'b0;
      return up;
   endfunction

   // Returns {value, invalid, inexact}; out-of-range saturates positive for both signs.
   function automatic logic [INTn+1:0] finish(input logic sgn, input logic [INTn-1:0] mag,
                                              input logic inc, input logic grd,
                                              input logic stk, input logic ovf);
      logic [INTn:0]   rmag;
      logic [INTn-1:0] val;
      rmag = {1'b0, mag} + {{INTn{1'b0}}, inc};
      if (ovf || (!sgn && rmag > {1'b0, INTn'(SAT_POS)}) || (sgn && rmag > {1'b0, INTn'(SAT_NEG)}))
         return {INTn'(SAT_POS), 1'b1, 1'b0};
      val = sgn ? -rmag[INTn-1:0] : rmag[INTn-1:0];
      return {val, 1'b0, grd | stk};
   endfunction

   logic en;
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // ---- S1: unpack ----
   logic [NEXP-1:0] expField;
   logic [NSIG-1:0] fracField;
   fpClass_t        clsIn;

   assign expField  = in_float[NEXP+NSIG-1:NSIG];
   assign fracField = in_float[NSIG-1:0];

   always_comb begin
      clsIn = clsNormal;
      if (expField == '0)      clsIn = (fracField == '0) ? clsZero : clsDenorm;
      else if (expField == '1) clsIn = (fracField == '0) ? clsInf : clsNan;
   end

   logic                    vld_p1, sign_p1;
   logic signed [NEXP:0]    exp_p1;
   logic [NSIG:0]           sig_p1;
   fpClass_t                cls_p1;
   logic [LAST_RA:0]        ra_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     vld_p1 <= 1'b0;
      else if (en) vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         sign_p1 <= in_float[NEXP+NSIG];
         exp_p1  <= $signed({1'b0, expField}) - $signed((NEXP+1)'(BIAS));
         sig_p1  <= {expField != '0, fracField};
         cls_p1  <= clsIn;
         ra_p1   <= ra;
      end
   end

   // ---- S2: align ----
   logic [SHW-1:0]  rshAmt;
   logic [NEXP:0]   lshAmt;
   logic [INTn-1:0] rMag, magN;
   logic            rGuard, rSticky, guardN, stickyN, ovfN;

   assign rshAmt = SHW'(E_SIG - exp_p1);
   assign lshAmt = exp_p1 - E_SIG;

   rshift_sticky #(.SIGW(NSIG + 1), .OUTW(INTn), .SHW(SHW)) uShift (
      .sig    (sig_p1),
      .shAmt  (rshAmt),
      .mag    (rMag),
      .guard  (rGuard),
      .sticky (rSticky)
   );

   always_comb begin
      magN    = '0;
      guardN  = 1'b0;
      stickyN = 1'b0;
      ovfN    = 1'b0;
      case (cls_p1)
         clsZero:   ;
         clsDenorm: stickyN = 1'b1;
         clsNormal: begin
            if (exp_p1 > E_SAT)
               ovfN = 1'b1;
            else if (exp_p1 == E_SAT) begin
               // -2^31 is the only representable value at this exponent.
               if (sign_p1 && sig_p1[NSIG-1:0] == '0) magN = INTn'(SAT_NEG);
               else ovfN = 1'b1;
            end
            else if (exp_p1 > E_SIG)
               magN = INTn'(sig_p1) << lshAmt;
            else if (exp_p1 >= E_ZERO) begin
               magN    = rMag;
               guardN  = rGuard;
               stickyN = rSticky;
            end
            else if (exp_p1 == E_NEG1) begin
               guardN  = 1'b1;
               stickyN = |sig_p1[NSIG-1:0];
            end
            else
               stickyN = 1'b1;
         end
         default:   ovfN = 1'b1;
      endcase
   end

   logic             vld_p2, sign_p2, guard_p2, sticky_p2, ovf_p2;
   logic [INTn-1:0]  mag_p2;
   logic [LAST_RA:0] ra_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     vld_p2 <= 1'b0;
      else if (en) vld_p2 <= vld_p1;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         sign_p2   <= sign_p1;
         mag_p2    <= magN;
         guard_p2  <= guardN;
         sticky_p2 <= stickyN;
         ovf_p2    <= ovfN;
         ra_p2     <= ra_p1;
      end
   end

   // ---- S3: round, negate, saturate ----
   logic [INTn+1:0] res;

   assign res = finish(sign_p2, mag_p2,
                       roundUp(ra_p2, sign_p2, mag_p2[0], guard_p2, sticky_p2),
                       guard_p2, sticky_p2, ovf_p2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_int     <= '0;
         out_invalid <= 1'b0;
         out_inexact <= 1'b0;
      end
      else if (en) begin
         out_valid <= vld_p2;
         if (vld_p2) begin
            out_int     <= res[INTn+1:2];
            out_invalid <= res[1];
            out_inexact <= res[0];
         end
      end
   end

endmodule

// File: tb/tb_cvt_w_s.sv
// Bench for cvt_w_s: directed rounding/range/special cases, backpressure,
// mid-flight reset and a randomized stream against a value-level model.
module tb_cvt_w_s;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_float = '0;
   logic [3:0]  ra = 4'b0001;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_int;
   logic        out_invalid;
   logic        out_inexact;

   localparam logic [3:0] RNE = 4'b0001;
   localparam logic [3:0] RTZ = 4'b0010;
   localparam logic [3:0] RTP = 4'b0100;
   localparam logic [3:0] RTN = 4'b1000;

   typedef struct {
      logic [31:0] val;
      logic        inv;
      logic        inx;
      int          tcyc;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t expQ[$];
   exp_t pendExp;
   bit   chkLat = 0;
   bit   randReady = 0;
   bit   holding = 0;
   bit   sawStall = 0;
   logic [31:0] heldInt;

   cvt_w_s dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_float    (in_float),
      .ra          (ra),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_int     (out_int),
      .out_invalid (out_invalid),
      .out_inexact (out_inexact)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] v, input logic iv, input logic ix);
      exp_t x;
      x.val = v; x.inv = iv; x.inx = ix; x.tcyc = 0;
      return x;
   endfunction

   // Operand value is sig * 2^-n; the integer part and remainder decide rounding.
   function automatic exp_t model(input logic [31:0] f, input logic [3:0] r);
      exp_t   res;
      int     e, n;
      longint sig, q, rem, half, v;
      bit     up, s;
      res = mk(32'h7FFF_FFFF, 1'b1, 1'b0);
      s = f[31];
      e = int'(f[30:23]);
      if (e == 255) return res;
      sig = longint'(f[22:0]);
      if (e != 0) sig = sig + 64'sd8388608;
      n = 150 - ((e == 0) ? 1 : e);
      if (n <= 0) begin
         if (n < -20) return res;
         q = sig << (-n); rem = 0; half = 1;
      end
      else if (n > 60) begin
         q = 0; rem = (sig != 0) ? 1 : 0; half = 2;
      end
      else begin
         q = sig >> n; rem = sig - (q << n); half = 64'sd1 << (n - 1);
      end
      up = 0;
      if (rem != 0) begin
         if (r == RNE) up = (rem > half) || (rem == half && q[0]);
         if (r == RTP) up = !s;
         if (r == RTN) up = s;
      end
      v = q + longint'(up);
      if (s) v = -v;
      if (v > 64'sd2147483647 || v < -64'sd2147483648) return res;
      res.val = v[31:0]; res.inv = 1'b0; res.inx = (rem != 0);
      return res;
   endfunction

   function automatic logic [31:0] rndFloat();
      logic [7:0]  e;
      logic [22:0] fr;
      int          p;
      p = $urandom_range(0, 9);
      if (p < 6)       e = 8'($urandom_range(100, 160));
      else if (p == 6) e = 8'h00;
      else if (p == 7) e = 8'($urandom_range(155, 159));
      else             e = 8'($urandom);
      fr = 23'($urandom);
      if ($urandom_range(0, 3) == 0) fr[15:0] = '0;
      return {1'($urandom), e, fr};
   endfunction

   function automatic logic [3:0] rndRa();
      return 4'b0001 << $urandom_range(0, 3);
   endfunction

   // One clock: called at a negedge with inputs already driven.
   task automatic step(output bit took);
      exp_t e;
      if (randReady) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (holding) begin
         total++;
         assert (out_valid === 1'b1 && out_int === heldInt)
         else begin
            bad++;
            $error("FAIL stall_hold got=%h/%b want=%h/1", out_int, out_valid, heldInt);
         end
      end
      holding = 0;
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
         total++;
         assert (in_ready === 1'b0)
         else begin bad++; $error("FAIL stall_in_ready got=%b want=0", in_ready); end
         holding = 1; heldInt = out_int; sawStall = 1;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         assert (expQ.size() != 0)
         else begin bad++; $error("FAIL spurious_result got=%h want=none", out_int); end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            total++;
            assert (out_int === e.val && out_invalid === e.inv && out_inexact === e.inx)
            else begin
               bad++;
               $error("FAIL result got=%h inv=%b inx=%b want=%h inv=%b inx=%b",
                      out_int, out_invalid, out_inexact, e.val, e.inv, e.inx);
            end
            if (chkLat) begin
               total++;
               assert (cyc - e.tcyc == 3)
               else begin bad++; $error("FAIL latency got=%0d want=3", cyc - e.tcyc); end
            end
         end
      end
      took = (in_valid === 1'b1 && in_ready === 1'b1);
      if (took) begin
         e = pendExp; e.tcyc = cyc;
         expQ.push_back(e);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive(input logic [31:0] f, input logic [3:0] r, input exp_t e);
      bit took;
      int n;
      n = 0;
      in_valid = 1'b1; in_float = f; ra = r; pendExp = e;
      do begin step(took); n++; end while (!took && n < 60);
      total++;
      assert (took)
      else begin bad++; $error("FAIL accept_timeout got=no transfer want=transfer f=%h", f); end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int idle);
      bit took;
      int n;
      n = 0;
      in_valid = 1'b0; randReady = 0; out_ready = 1'b1;
      while (expQ.size() != 0 && n < 200) begin step(took); n++; end
      total++;
      assert (expQ.size() == 0)
      else begin bad++; $error("FAIL drain_timeout got=%0d left want=0", expQ.size()); end
      repeat (idle) step(took);
   endtask

   typedef struct {
      logic [31:0] f;
      logic [3:0]  r;
      logic [31:0] v;
      logic        iv;
      logic        ix;
   } vec_t;

   vec_t dir[] = '{
      '{32'h3FC0_0000, RNE, 32'h0000_0002, 1'b0, 1'b1},
      '{32'h4020_0000, RNE, 32'h0000_0002, 1'b0, 1'b1},
      '{32'hC020_0000, RTN, 32'hFFFF_FFFD, 1'b0, 1'b1},
      '{32'h0000_0001, RTP, 32'h0000_0001, 1'b0, 1'b1},
      '{32'h0000_0001, RTZ, 32'h0000_0000, 1'b0, 1'b1},
      '{32'h8000_0000, RNE, 32'h0000_0000, 1'b0, 1'b0},
      '{32'hCF00_0000, RNE, 32'h8000_0000, 1'b0, 1'b0},
      '{32'h4F00_0000, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h4EFF_FFFF, RNE, 32'h7FFF_FF80, 1'b0, 1'b0},
      '{32'h7FC0_0000, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h7F80_0000, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hFF80_0000, RTN, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hBF00_0000, RNE, 32'h0000_0000, 1'b0, 1'b1},
      '{32'hBF00_0000, RTN, 32'hFFFF_FFFF, 1'b0, 1'b1},
      '{32'h3F40_0000, RNE, 32'h0000_0001, 1'b0, 1'b1},
      '{32'hCF00_0001, RNE, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h4B7F_FFFF, RNE, 32'h00FF_FFFF, 1'b0, 1'b0},
      '{32'h3FFF_FFFF, RTZ, 32'h0000_0001, 1'b0, 1'b1},
      '{32'h3FFF_FFFF, RTP, 32'h0000_0002, 1'b0, 1'b1},
      '{32'h3F80_0000, RNE, 32'h0000_0001, 1'b0, 1'b0}
   };

   logic [31:0] bpF[8];
   logic [3:0]  bpR[8];

   initial begin
      bit took;
      int sent, k;

      // Reset state
      rst = 1'b1; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      assert (out_valid === 1'b0) else begin bad++; $error("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++;
      assert (out_int === 32'h0) else begin bad++; $error("FAIL rst_out_int got=%h want=0", out_int); end
      total++;
      assert (out_invalid === 1'b0 && out_inexact === 1'b0)
      else begin bad++; $error("FAIL rst_flags got=%b%b want=00", out_invalid, out_inexact); end
      rst = 1'b0;
      #1;
      total++;
      assert (in_ready === 1'b1) else begin bad++; $error("FAIL rst_in_ready got=%b want=1", in_ready); end
      @(negedge clk); cyc++;

      // Directed vectors, back-to-back with no stall
      chkLat = 1;
      foreach (dir[i]) drive(dir[i].f, dir[i].r, mk(dir[i].v, dir[i].iv, dir[i].ix));
      drain(3);
      chkLat = 0;

      // Backpressure: 8 operands, out_ready low for cycles 4..9
      foreach (bpF[i]) begin bpF[i] = rndFloat(); bpR[i] = rndRa(); end
      sent = 0; k = 0; sawStall = 0;
      while ((sent < 8 || expQ.size() != 0) && k < 100) begin
         out_ready = !(k >= 4 && k <= 9);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_float = bpF[sent]; ra = bpR[sent]; pendExp = model(bpF[sent], bpR[sent]);
         end
         if (k >= 10 && expQ.size() != 0) begin
            total++;
            assert (out_valid === 1'b1)
            else begin bad++; $error("FAIL bp_one_per_cycle got=%b want=1 k=%0d", out_valid, k); end
         end
         step(took);
         if (took) sent++;
         k++;
      end
      in_valid = 1'b0;
      total++;
      assert (sent == 8 && expQ.size() == 0)
      else begin bad++; $error("FAIL bp_complete got=%0d/%0d want=8/0", sent, expQ.size()); end
      total++;
      assert (sawStall) else begin bad++; $error("FAIL bp_stall_seen got=0 want=1"); end
      drain(2);

      // Reset with three operands in flight
      out_ready = 1'b0;
      drive(32'h4040_0000, RNE, mk(32'h3, 1'b0, 1'b0));
      drive(32'h4080_0000, RNE, mk(32'h4, 1'b0, 1'b0));
      drive(32'h40A0_0000, RNE, mk(32'h5, 1'b0, 1'b0));
      #1;
      total++;
      assert (out_valid === 1'b1) else begin bad++; $error("FAIL pre_reset_valid got=%b want=1", out_valid); end
      #1 rst = 1'b1;
      #1;
      total++;
      assert (out_valid === 1'b0 && out_int === 32'h0)
      else begin bad++; $error("FAIL async_reset got=%b/%h want=0/0", out_valid, out_int); end
      expQ.delete(); holding = 0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0; out_ready = 1'b1; cyc += 2;
      repeat (4) step(took);
      chkLat = 1;
      drive(32'hC0E0_0000, RTZ, mk(32'hFFFF_FFF9, 1'b0, 1'b0));
      drain(3);
      chkLat = 0;

      // Randomized stream with random stalls and input gaps
      randReady = 1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] f;
         logic [3:0]  r;
         f = rndFloat(); r = rndRa();
         drive(f, r, model(f, r));
         if ($urandom_range(0, 4) == 0) begin
            randReady = 1;
            step(took);
         end
      end
      drain(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
